// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the multi-cycle ALU: opcode encodings,
//             controller state encoding and the default datapath width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam int DEF_WIDTH = 32;

   localparam logic [3:0] OP_OR   = 4'b0000;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_MUL  = 4'b0100;
   localparam logic [3:0] OP_ADDI = 4'b0101;
   localparam logic [3:0] OP_LD   = 4'b0110;
   localparam logic [3:0] OP_SD   = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_iter
//  Purpose  : Iterative shift-add multiplier returning the low WIDTH bits of
//             A*B, retiring MUL_BPC multiplier bits per clock.
//  Ports    : clk_i, rst_i (async, active-low)
//             i_start  - load operands and clear accumulator/counter
//             i_a,i_b  - multiplicand / multiplier
//             o_result - accumulator value including this cycle's step
//             o_done   - high during the final step; o_result is then final
//  Revision : 1.0  initial release
// ============================================================================
module alu_mul_iter #(
   parameter int WIDTH   = 32,
   parameter int MUL_BPC = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_done
);

   localparam int STEPS = WIDTH / MUL_BPC;
   localparam int CNT_W = $clog2(STEPS + 1);

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;

   logic [WIDTH-1:0] w_digit;
   logic [WIDTH-1:0] w_part;
   logic [WIDTH-1:0] w_acc_next;
   logic             w_last;

   // The multiplicand is pre-shifted each step instead of shifting the
   // partial product by cnt*MUL_BPC; the sum is identical.
   assign w_digit    = WIDTH'(r_b[MUL_BPC-1:0]);
   assign w_part     = r_a * w_digit;
   assign w_acc_next = r_acc + w_part;
   assign w_last     = r_busy && (r_cnt == CNT_W'(STEPS - 1));

   assign o_result = w_acc_next;
   assign o_done   = w_last;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_acc  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_acc  <= '0;
         r_a    <= i_a;
         r_b    <= i_b;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_acc <= w_acc_next;
         r_a   <= r_a << MUL_BPC;
         r_b   <= r_b >> MUL_BPC;
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : Multi-cycle ALU with valid/ready handshakes on both sides.
//             Single-cycle ops register their result at the handshake edge;
//             MUL runs through the iterative multiplier.
//  Ports    : clk_i, rst_i (async, active-low)
//             valid_i/ready_o            - request handshake
//             data1_i, data2_i, control_i - operands and opcode
//             valid_o/ready_i            - result handshake
//             data_o, zero_o, ovf_o      - result and flags
//  Revision : 1.0  initial release
// ============================================================================
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MUL_BPC = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic [3:0]       control_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o,
   output logic             ovf_o
);

   state_t           r_state;
   state_t           w_state_next;
   logic             w_hs;
   logic             w_is_mul;
   logic             w_mul_start;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_res;

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_res;
   logic             w_known;
   logic             w_zero;
   logic             w_ovf;

   logic [WIDTH-1:0] r_data;
   logic             r_zero;
   logic             r_ovf;

   assign w_hs     = valid_i && ready_o;
   assign w_is_mul = (control_i == OP_MUL);

   // ---------------- controller ----------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_mul_start  = 1'b0;
      ready_o      = 1'b0;
      valid_o      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               if (w_is_mul) begin
                  w_state_next = ST_MUL;
                  w_mul_start  = 1'b1;
               end else begin
                  w_state_next = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            if (w_mul_done) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            valid_o = 1'b1;
            if (ready_i) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ---------------- single-cycle datapath ----------------
   assign w_sum  = data1_i + data2_i;
   assign w_diff = data1_i - data2_i;

   always_comb begin
      w_res   = '0;
      w_known = 1'b1;
      w_ovf   = 1'b0;
      case (control_i)
         OP_OR:  w_res = data1_i | data2_i;
         OP_AND: w_res = data1_i & data2_i;
         OP_ADD, OP_ADDI, OP_LD, OP_SD: begin
            w_res = w_sum;
            w_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) &&
                    (w_sum[WIDTH-1]   != data1_i[WIDTH-1]);
         end
         OP_SUB, OP_BEQ: begin
            w_res = w_diff;
            w_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) &&
                    (w_diff[WIDTH-1]  != data1_i[WIDTH-1]);
         end
         default: w_known = 1'b0;
      endcase
      // Unknown opcodes report zero_o=0 even though their result is 0.
      if (control_i == OP_BEQ) begin
         w_zero = (data1_i == data2_i);
      end else begin
         w_zero = w_known && (w_res == '0);
      end
   end

   alu_mul_iter #(
      .WIDTH   (WIDTH),
      .MUL_BPC (MUL_BPC)
   ) u_mul (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_start  (w_mul_start),
      .i_a      (data1_i),
      .i_b      (data2_i),
      .o_result (w_mul_res),
      .o_done   (w_mul_done)
   );

   // Result registers only load on capture events, so they hold through
   // DONE backpressure and keep their value after returning to IDLE.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_data <= '0;
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_hs && !w_is_mul) begin
         r_data <= w_res;
         r_zero <= w_zero;
         r_ovf  <= w_ovf;
      end else if ((r_state == ST_MUL) && w_mul_done) begin
         r_data <= w_mul_res;
         r_zero <= (w_mul_res == '0);
         r_ovf  <= 1'b0;
      end
   end

   assign data_o = r_data;
   assign zero_o = r_zero;
   assign ovf_o  = r_ovf;

endmodule : alu_mc
`default_nettype wire
